// File: rtl/line_pixel_writer_if.sv
// -----------------------------------------------------------------------------
// line_pixel_writer_if
// Bundles the pixel-strobe side, the framebuffer write side and the status
// outputs of line_pixel_writer.
//   slave  : view used by line_pixel_writer (consumes pix_*/fb_ack, drives the rest)
//   master : view used by the pixel source / framebuffer model
// Signals:
//   pix_wr, pix_x[9:0], pix_y[9:0], pix_color[11:0]  pixel strobe from line drawer
//   fb_req, fb_addr[18:0], fb_data[11:0], fb_ack     framebuffer write handshake
//   full, idle, overflow, clip_cnt[15:0]             status
// -----------------------------------------------------------------------------
interface line_pixel_writer_if;
  logic        pix_wr;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_color;
  logic        fb_req;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_ack;
  logic        full;
  logic        idle;
  logic        overflow;
  logic [15:0] clip_cnt;

  modport slave (
    input  pix_wr, pix_x, pix_y, pix_color, fb_ack,
    output fb_req, fb_addr, fb_data, full, idle, overflow, clip_cnt
  );

  modport master (
    output pix_wr, pix_x, pix_y, pix_color, fb_ack,
    input  fb_req, fb_addr, fb_data, full, idle, overflow, clip_cnt
  );
endinterface

// File: rtl/line_pixel_writer.sv
// -----------------------------------------------------------------------------
// line_pixel_writer
// Takes pixel strobes from a line drawer, clips them against the visible
// area, converts (x,y) to a linear framebuffer address, buffers them in a
// DEPTH-entry FIFO and issues them as framebuffer write requests, one per
// cycle while the framebuffer keeps acknowledging.
// Ports:
//   pclk   : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : line_pixel_writer_if.slave (pixel strobe, fb handshake, status)
// -----------------------------------------------------------------------------
module line_pixel_writer #(
  parameter int DEPTH = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              pclk,
  input  logic              rst_n,
  line_pixel_writer_if.slave bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_0   = {CW{1'b0}};
  localparam logic [10:0]     H_LIM   = 11'(H_RES);
  localparam logic [10:0]     V_LIM   = 11'(V_RES);
  localparam logic [18:0]     H_MUL   = 19'(H_RES);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_REQ   = 1'b1
  } state_e;

  // FIFO storage: address and colour kept side by side per entry
  logic [18:0]   addr_mem [DEPTH];
  logic [11:0]   data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  state_e        state_q;
  logic          fb_req_q;
  logic [18:0]   fb_addr_q;
  logic [11:0]   fb_data_q;
  logic          overflow_q;
  logic [15:0]   clip_cnt_q;

  logic          in_range_s;
  logic          push_s;
  logic          drop_full_s;
  logic          clip_s;
  logic          pop_s;
  logic [18:0]   pix_addr_s;

  // Strobe classification, address computation and pop decision
  always_comb begin
    in_range_s  = ({1'b0, bus.pix_x} < H_LIM) && ({1'b0, bus.pix_y} < V_LIM);
    pix_addr_s  = ({9'd0, bus.pix_y} * H_MUL) + {9'd0, bus.pix_x};
    clip_s      = bus.pix_wr && !in_range_s;
    // A full FIFO refuses the strobe even when a pop frees a slot this cycle.
    push_s      = bus.pix_wr && in_range_s && (count_q != DEPTH_C);
    drop_full_s = bus.pix_wr && in_range_s && (count_q == DEPTH_C);
    if (count_q != CNT_0) begin
      if (state_q == ST_EMPTY) begin
        pop_s = 1'b1;
      end else begin
        pop_s = bus.fb_ack;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO entry write; contents need no reset since pointers gate visibility
  always_ff @(posedge pclk) begin
    if (push_s) begin
      addr_mem[wr_ptr_q] <= pix_addr_s;
      data_mem[wr_ptr_q] <= bus.pix_color;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= CNT_0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output stage FSM with registered request, address and colour
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      fb_req_q  <= 1'b0;
      fb_addr_q <= 19'd0;
      fb_data_q <= 12'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pop_s) begin
            state_q   <= ST_REQ;
            fb_req_q  <= 1'b1;
            fb_addr_q <= addr_mem[rd_ptr_q];
            fb_data_q <= data_mem[rd_ptr_q];
          end
        end
        ST_REQ: begin
          if (bus.fb_ack) begin
            if (pop_s) begin
              fb_addr_q <= addr_mem[rd_ptr_q];
              fb_data_q <= data_mem[rd_ptr_q];
            end else begin
              state_q  <= ST_EMPTY;
              fb_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= ST_EMPTY;
          fb_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag and saturating clip counter
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      clip_cnt_q <= 16'd0;
    end else begin
      if (drop_full_s) begin
        overflow_q <= 1'b1;
      end
      if (clip_s && (clip_cnt_q != 16'hFFFF)) begin
        clip_cnt_q <= clip_cnt_q + 16'd1;
      end
    end
  end

  assign bus.fb_req   = fb_req_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign bus.full     = (count_q == DEPTH_C);
  assign bus.idle     = (count_q == CNT_0) && (state_q == ST_EMPTY);
  assign bus.overflow = overflow_q;
  assign bus.clip_cnt = clip_cnt_q;

endmodule

// File: tb/tb_line_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_line_pixel_writer
// Directed vectors with hand-computed expectations plus a randomized run
// against an in-order scoreboard. Inputs change 1ns after the rising edge;
// framebuffer handshakes are captured on the falling edge.
// -----------------------------------------------------------------------------
module tb_line_pixel_writer;

  logic pclk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  line_pixel_writer_if bus_if ();

  line_pixel_writer #(
    .DEPTH (16),
    .H_RES (640),
    .V_RES (480)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Accepted framebuffer writes as {addr, data}
  logic [30:0] wr_q [$];

  always @(negedge pclk) begin
    if (rst_n && bus_if.fb_req && bus_if.fb_ack) begin
      wr_q.push_back({bus_if.fb_addr, bus_if.fb_data});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_pix(input logic wr, input int x, input int y, input logic [11:0] c);
    bus_if.pix_wr    = wr;
    bus_if.pix_x     = 10'(x);
    bus_if.pix_y     = 10'(y);
    bus_if.pix_color = c;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [30:0] exp_q [$];
  logic [30:0] w;
  int          n_strobes;
  int          n_clip;
  int          skipped;
  int          bad;
  int          seq;
  int          rx;
  int          ry;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_pix(1'b0, 0, 0, 12'h000);
    bus_if.fb_ack = 1'b0;
    tick();
    tick();

    // Reset state while rst_n is low
    check_eq("rst_fb_req",   32'(bus_if.fb_req),   32'd0);
    check_eq("rst_fb_addr",  32'(bus_if.fb_addr),  32'd0);
    check_eq("rst_fb_data",  32'(bus_if.fb_data),  32'd0);
    check_eq("rst_full",     32'(bus_if.full),     32'd0);
    check_eq("rst_idle",     32'(bus_if.idle),     32'd1);
    check_eq("rst_overflow", 32'(bus_if.overflow), 32'd0);
    check_eq("rst_clip_cnt", 32'(bus_if.clip_cnt), 32'd0);
    rst_n = 1'b1;

    // Single pixel at (3,2): 2*640+3 = 1283
    wr_q.delete();
    bus_if.fb_ack = 1'b1;
    set_pix(1'b1, 3, 2, 12'hF00);
    tick();
    set_pix(1'b0, 0, 0, 12'h000);
    check_eq("single_req_k",   32'(bus_if.fb_req),  32'd0);
    check_eq("single_idle_k",  32'(bus_if.idle),    32'd0);
    tick();
    check_eq("single_req_k1",  32'(bus_if.fb_req),  32'd1);
    check_eq("single_addr",    32'(bus_if.fb_addr), 32'd1283);
    check_eq("single_data",    32'(bus_if.fb_data), 32'h0F00);
    tick();
    check_eq("single_req_k2",  32'(bus_if.fb_req),  32'd0);
    check_eq("single_idle_k2", 32'(bus_if.idle),    32'd1);
    check_eq("single_nwr",     32'(wr_q.size()),    32'd1);

    // Stall: five strobes x=0..4 with ack low, then one write per cycle
    wr_q.delete();
    bus_if.fb_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pix(1'b1, i, 0, 12'(12'h100 + i));
      tick();
    end
    set_pix(1'b0, 0, 0, 12'h000);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_req",  32'(bus_if.fb_req),  32'd1);
      check_eq("stall_addr", 32'(bus_if.fb_addr), 32'd0);
      check_eq("stall_data", 32'(bus_if.fb_data), 32'h100);
      tick();
    end
    bus_if.fb_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check_eq("stall_burst_req",  32'(bus_if.fb_req),  32'd1);
      check_eq("stall_burst_addr", 32'(bus_if.fb_addr), 32'(i));
    end
    tick();
    check_eq("stall_end_req", 32'(bus_if.fb_req), 32'd0);
    check_eq("stall_nwr",     32'(wr_q.size()),   32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_q.size()) begin
        w = wr_q[i];
        check_eq("stall_order_addr", 32'(w[30:12]), 32'(i));
        check_eq("stall_order_data", 32'(w[11:0]),  32'(12'h100 + i));
      end
    end

    // Overflow: 20 strobes at row 1 with ack low
    wr_q.delete();
    bus_if.fb_ack = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      set_pix(1'b1, n - 1, 1, 12'(n));
      tick();
      check_eq("ovf_full", 32'(bus_if.full),     (n >= 17) ? 32'd1 : 32'd0);
      check_eq("ovf_flag", 32'(bus_if.overflow), (n >= 18) ? 32'd1 : 32'd0);
    end
    set_pix(1'b0, 0, 0, 12'h000);
    bus_if.fb_ack = 1'b1;
    repeat (30) tick();
    check_eq("ovf_nwr",       32'(wr_q.size()),      32'd17);
    check_eq("ovf_full_end",  32'(bus_if.full),      32'd0);
    check_eq("ovf_idle_end",  32'(bus_if.idle),      32'd1);
    check_eq("ovf_sticky",    32'(bus_if.overflow),  32'd1);
    for (int i = 0; i < 17; i++) begin
      if (i < wr_q.size()) begin
        w = wr_q[i];
        check_eq("ovf_order_addr", 32'(w[30:12]), 32'(640 + i));
      end
    end

    // Clipping: two out of range, one at the far corner (479*640+639)
    pulse_reset();
    check_eq("clip_ovf_cleared", 32'(bus_if.overflow), 32'd0);
    wr_q.delete();
    bus_if.fb_ack = 1'b1;
    set_pix(1'b1, 640, 0,   12'h00A);
    tick();
    set_pix(1'b1, 0,   480, 12'h00B);
    tick();
    set_pix(1'b1, 639, 479, 12'h00C);
    tick();
    set_pix(1'b0, 0, 0, 12'h000);
    repeat (5) tick();
    check_eq("clip_cnt",  32'(bus_if.clip_cnt), 32'd2);
    check_eq("clip_nwr",  32'(wr_q.size()),     32'd1);
    if (wr_q.size() > 0) begin
      w = wr_q[0];
      check_eq("clip_addr", 32'(w[30:12]), 32'd307199);
      check_eq("clip_data", 32'(w[11:0]),  32'h00C);
    end

    // Reset mid-burst: 8 pixels plus one clipped, ack low, then reset pulse
    pulse_reset();
    wr_q.delete();
    bus_if.fb_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_pix(1'b1, 10 + i, 5, 12'h0EE);
      tick();
    end
    set_pix(1'b1, 700, 5, 12'h0EE);
    tick();
    set_pix(1'b0, 0, 0, 12'h000);
    check_eq("mid_req_before",  32'(bus_if.fb_req),   32'd1);
    check_eq("mid_clip_before", 32'(bus_if.clip_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_req_async",  32'(bus_if.fb_req), 32'd0);
    check_eq("mid_idle_async", 32'(bus_if.idle),   32'd1);
    tick();
    rst_n = 1'b1;
    bus_if.fb_ack = 1'b1;
    repeat (20) tick();
    check_eq("mid_nwr",      32'(wr_q.size()),      32'd0);
    check_eq("mid_req",      32'(bus_if.fb_req),    32'd0);
    check_eq("mid_idle",     32'(bus_if.idle),      32'd1);
    check_eq("mid_overflow", 32'(bus_if.overflow),  32'd0);
    check_eq("mid_clip",     32'(bus_if.clip_cnt),  32'd0);

    // Random traffic against an in-order scoreboard
    pulse_reset();
    wr_q.delete();
    exp_q.delete();
    n_strobes = 0;
    n_clip    = 0;
    seq       = 0;
    for (int c = 0; c < 10000; c++) begin
      rx = int'($urandom_range(0, 700));
      ry = int'($urandom_range(0, 520));
      bus_if.fb_ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        set_pix(1'b1, rx, ry, 12'(seq));
        n_strobes++;
        if (rx < 640 && ry < 480) begin
          exp_q.push_back({19'(ry * 640 + rx), 12'(seq)});
          seq++;
        end else begin
          n_clip++;
        end
      end else begin
        set_pix(1'b0, 0, 0, 12'h000);
      end
      tick();
    end
    set_pix(1'b0, 0, 0, 12'h000);
    bus_if.fb_ack = 1'b1;
    repeat (40) tick();
    skipped = 0;
    bad     = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      while (exp_q.size() > 0 && exp_q[0] !== wr_q[i]) begin
        void'(exp_q.pop_front());
        skipped++;
      end
      if (exp_q.size() == 0) begin
        bad++;
      end else begin
        void'(exp_q.pop_front());
      end
    end
    check_eq("rand_unmatched", 32'(bad),              32'd0);
    check_eq("rand_leftover",  32'(exp_q.size()),     32'd0);
    check_eq("rand_clip",      32'(bus_if.clip_cnt),  32'(n_clip));
    check_eq("rand_balance",   32'(wr_q.size() + int'(bus_if.clip_cnt) + skipped), 32'(n_strobes));
    check_eq("rand_drop_ovf",  32'(skipped != 0),     32'(bus_if.overflow));
    check_eq("rand_idle",      32'(bus_if.idle),      32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
